// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared constants and FSM encoding for the sequential shift-and-add multiplier.
package seq_shift_add_multiplier_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 5;

    // 2'd3 is unreachable; the FSM falls back to IDLE from it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shift_add_multiplier_adder.sv
// 16-bit carry-select adder: 4-bit ripple blocks, each precomputed for carry-in 0 and 1.
module carry_select_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    localparam int BLK = 4;
    localparam int NB  = 16 / BLK;

    logic [NB:0] c;
    assign c[0] = cin;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLK:0] s0, s1;
        assign s0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
        assign s1 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]} + 5'd1;
        assign sum[g*BLK +: BLK] = c[g] ? s1[BLK-1:0] : s0[BLK-1:0];
        assign c[g+1]            = c[g] ? s1[BLK]     : s0[BLK];
    end

    assign cout = c[NB];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// 16x16 unsigned sequential multiplier: one adder pass per cycle, 16 iterations,
// valid/ready on both operand input and product output.
module seq_shift_add_multiplier
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,  // must stay 16 to match the adder
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    state_t             state, state_nx;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] p;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               last_iter;

    carry_select_adder_16bit u_add (
        .a    (p[2*WIDTH-1:WIDTH]),
        .b    (m),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign product   = p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last_iter) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Upper half accumulates M when the current multiplier bit is set; the whole
    // register then shifts right, so the adder carry lands in the top bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m   <= '0;
            p   <= '0;
            cnt <= '0;
        end else if (state == IDLE && in_valid) begin
            m   <= a;
            p   <= {{WIDTH{1'b0}}, b};
            cnt <= '0;
        end else if (state == RUN) begin
            p   <= p[0] ? {cout, sum, p[WIDTH-1:1]} : {1'b0, p[2*WIDTH-1:1]};
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: vector table plus scoreboard on the output handshake.
module tb_seq_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] product;

    seq_shift_add_multiplier #(.WIDTH(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        int          hold;     // cycles of back-pressure in DONE
        bit          pulse;    // pulse in_valid during DONE
        bit          scramble; // change a/b during RUN
    } vec_t;

    int          nchk = 0;
    int          npass = 0;
    int          cyc = 0;
    int          nout = 0;
    logic [31:0] sbq[$];
    int          acc_cyc[$];

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    // Scoreboard: push the model product on accept, pop and compare on output handshake.
    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                sbq.push_back(32'(a) * 32'(b));
                acc_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                nout++;
                if (sbq.size() == 0) check("sb_unexpected_output", product, 32'hx);
                else check("sb_product", product, sbq.pop_front());
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v);
        int t;
        int lat;
        a = v.a;
        b = v.b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        t = 0;
        while (!in_ready && t < 50) begin step(); t++; end
        check("accept_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("in_ready_in_run", 32'(in_ready), 32'd0);
        if (v.scramble) begin a = 16'hFFFF; b = 16'hFFFF; end
        lat = 0;
        while (!out_valid && lat < 40) begin step(); lat++; end
        check("latency", 32'(lat), 32'd16);
        for (int i = 0; i < v.hold; i++) begin
            check("hold_product", product, v.exp);
            check("hold_valid", 32'(out_valid), 32'd1);
            if (v.pulse && i == 3) begin in_valid = 1'b1; a = 16'h2; b = 16'h3; end
            else in_valid = 1'b0;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("done_product", product, v.exp);
        step();
        out_ready = 1'b0;
        check("idle_after_handshake", {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    vec_t vt[$];

    initial begin
        int t;
        vt.push_back('{16'h9999, 16'h9FFF, 32'h5FFF0667, 0, 1'b0, 1'b0});
        vt.push_back('{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 1'b0, 1'b0});
        vt.push_back('{16'h0000, 16'h1234, 32'h00000000, 2, 1'b0, 1'b0});
        vt.push_back('{16'h0001, 16'hABCD, 32'h0000ABCD, 10, 1'b1, 1'b0});
        vt.push_back('{16'h0010, 16'h0010, 32'h00000100, 1, 1'b0, 1'b1});
        for (int i = 0; i < 3; i++) begin
            vec_t r;
            r.a = 16'($urandom);
            r.b = 16'($urandom);
            r.exp = 32'(r.a) * 32'(r.b);
            r.hold = i;
            r.pulse = 1'b0;
            r.scramble = 1'b1;
            vt.push_back(r);
        end

        #12;
        check("reset_outputs", {product[29:0], out_valid, in_ready}, 32'd1);
        check("reset_product", product, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        foreach (vt[i]) run_op(vt[i]);

        // Back-to-back with out_ready high: second accept 18 cycles after the first.
        acc_cyc.delete();
        a = 16'h9999; b = 16'h9FFF;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        a = 16'h0003; b = 16'h0005;
        t = 0;
        while (acc_cyc.size() < 2 && t < 60) begin step(); t++; end
        in_valid = 1'b0;
        check("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
        if (acc_cyc.size() >= 2) check("b2b_interval", 32'(acc_cyc[1] - acc_cyc[0]), 32'd18);
        t = 0;
        while ((sbq.size() != 0 || out_valid) && t < 40) begin step(); t++; end
        check("b2b_drained", 32'(sbq.size()), 32'd0);
        out_ready = 1'b0;

        // Reset at iteration 7 discards the operation immediately.
        a = 16'h1234; b = 16'h5678;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("pre_reset_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midreset_flags", {30'd0, out_valid, in_ready}, 32'd1);
        check("midreset_product", product, 32'd0);
        sbq.delete();
        step();
        rst_n = 1'b1;
        check("post_reset_idle", {30'd0, out_valid, in_ready}, 32'd1);
        run_op('{16'h1234, 16'h5678, 32'h06260060, 0, 1'b0, 1'b0});

        check("output_count", 32'(nout), 32'(vt.size() + 3));
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
